// File: rtl/cond_exec_stage.sv
// Execute-to-memory stage: holds the architectural NZCV register, evaluates the ARM
// condition field, gates write-enables and loads the EX/MEM register. Optional squash counter: CONDEX_SQUASH_CNT_EN.
module cond_exec_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ex_valid,
    input  logic         stall,
    input  logic         flush,
    input  logic [3:0]   cond,
    input  logic [1:0]   flag_write,
    input  logic         reg_write_in,
    input  logic         mem_write_in,
    input  logic         pc_src_in,
    input  logic         mem_to_reg_in,
    input  logic [3:0]   wa_in,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    input  logic [N-1:0] write_data,
    output logic         cond_ex,
    output logic [3:0]   flags_q,
    output logic         mem_valid,
    output logic         mem_reg_write,
    output logic         mem_mem_write,
    output logic         mem_pc_src,
    output logic         mem_mem_to_reg,
    output logic [3:0]   mem_wa,
    output logic [N-1:0] mem_alu_result,
    output logic [N-1:0] mem_write_data,
    output logic [15:0]  squash_count
);

    logic flag_n, flag_z, flag_c, flag_v;
    logic advance;
    logic execute;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = !flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = !flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = !flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = !flag_v;
            4'b1000: cond_ex = flag_c && !flag_z;
            4'b1001: cond_ex = !flag_c || flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = !flag_z && (flag_n == flag_v);
            4'b1101: cond_ex = flag_z || (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Pipeline handshake: an EX instruction moves to MEM on any edge with stall=0;
    // flush replaces it with a bubble, stall freezes both EX/MEM and flags_q and wins over flush.
    assign advance = !stall && !flush;
    assign execute = advance && ex_valid && cond_ex;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (execute) begin
            if (flag_write[1]) flags_q[3:2] <= alu_flags[3:2];
            if (flag_write[0]) flags_q[1:0] <= alu_flags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_valid      <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_pc_src     <= 1'b0;
            mem_mem_to_reg <= 1'b0;
            mem_wa         <= 4'h0;
            mem_alu_result <= '0;
            mem_write_data <= '0;
        end else if (!stall) begin
            if (flush) begin
                mem_valid      <= 1'b0;
                mem_reg_write  <= 1'b0;
                mem_mem_write  <= 1'b0;
                mem_pc_src     <= 1'b0;
                mem_mem_to_reg <= 1'b0;
            end else begin
                // A squashed instruction stays valid in MEM but with every side effect disabled.
                mem_valid      <= ex_valid;
                mem_reg_write  <= reg_write_in  && execute;
                mem_mem_write  <= mem_write_in  && execute;
                mem_pc_src     <= pc_src_in     && execute;
                mem_mem_to_reg <= mem_to_reg_in && execute;
                mem_wa         <= wa_in;
                mem_alu_result <= alu_result;
                mem_write_data <= write_data;
            end
        end
    end

`ifdef CONDEX_SQUASH_CNT_EN
    logic        squash;
    logic [15:0] squash_cnt_q;

    assign squash = advance && ex_valid && !cond_ex;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            squash_cnt_q <= 16'h0000;
        end else if (squash && (squash_cnt_q != 16'hFFFF)) begin
            squash_cnt_q <= squash_cnt_q + 16'h0001;
        end
    end

    assign squash_count = squash_cnt_q;
`else
    assign squash_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed bench for cond_exec_stage: condition table, flag updates, squash, stall/flush,
// reset and (with CONDEX_SQUASH_CNT_EN) squash counter saturation.
module tb_cond_exec_stage;

    localparam int N  = 32;
    localparam int PW = 5 + 4 + 2 * N;
`ifdef CONDEX_SQUASH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         ex_valid;
    logic         stall;
    logic         flush;
    logic [3:0]   cond;
    logic [1:0]   flag_write;
    logic         reg_write_in;
    logic         mem_write_in;
    logic         pc_src_in;
    logic         mem_to_reg_in;
    logic [3:0]   wa_in;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic [N-1:0] write_data;
    logic         cond_ex;
    logic [3:0]   flags_q;
    logic         mem_valid;
    logic         mem_reg_write;
    logic         mem_mem_write;
    logic         mem_pc_src;
    logic         mem_mem_to_reg;
    logic [3:0]   mem_wa;
    logic [N-1:0] mem_alu_result;
    logic [N-1:0] mem_write_data;
    logic [15:0]  squash_count;

    logic [PW-1:0] mem_pkt;
    logic [PW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [15:0]   exp_sq;
    logic [3:0]    tbl_flags[7];
    logic [15:0]   tbl_mask[7];
    logic [15:0]   mask;

    cond_exec_stage #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .stall(stall), .flush(flush),
        .cond(cond), .flag_write(flag_write), .reg_write_in(reg_write_in),
        .mem_write_in(mem_write_in), .pc_src_in(pc_src_in), .mem_to_reg_in(mem_to_reg_in),
        .wa_in(wa_in), .alu_result(alu_result), .alu_flags(alu_flags), .write_data(write_data),
        .cond_ex(cond_ex), .flags_q(flags_q), .mem_valid(mem_valid),
        .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write), .mem_pc_src(mem_pc_src),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_wa(mem_wa), .mem_alu_result(mem_alu_result),
        .mem_write_data(mem_write_data), .squash_count(squash_count)
    );

    assign mem_pkt = {mem_valid, mem_reg_write, mem_mem_write, mem_pc_src, mem_mem_to_reg,
                      mem_wa, mem_alu_result, mem_write_data};

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pkt(input logic v, input logic rw, input logic mw,
                                          input logic ps, input logic mtr, input logic [3:0] wa,
                                          input logic [N-1:0] alu, input logic [N-1:0] wd);
        return {v, rw, mw, ps, mtr, wa, alu, wd};
    endfunction

    task automatic set_instr(input logic v, input logic [3:0] c, input logic [1:0] fw,
                             input logic [3:0] af, input logic rw, input logic mw,
                             input logic ps, input logic mtr, input logic [3:0] wa,
                             input logic [N-1:0] alu, input logic [N-1:0] wd);
        ex_valid      = v;
        cond          = c;
        flag_write    = fw;
        alu_flags     = af;
        reg_write_in  = rw;
        mem_write_in  = mw;
        pc_src_in     = ps;
        mem_to_reg_in = mtr;
        wa_in         = wa;
        alu_result    = alu;
        write_data    = wd;
    endtask

    // Advance one edge, then score the EX/MEM register against the next expected packet.
    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) check_val(tag, mem_pkt, exp_q.pop_front());
    endtask

    task automatic set_flags(input logic [3:0] f);
        set_instr(1'b1, 4'hE, 2'b11, f, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
        exp_q.push_back(pkt(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0));
        tick("set_flags_mem");
        check_val("set_flags", flags_q, f);
    endtask

    initial begin
        tbl_flags = '{4'b0000, 4'b0100, 4'b0010, 4'b1001, 4'b1000, 4'b0110, 4'b0001};
        tbl_mask  = '{16'h56AA, 16'h66A9, 16'h55A6, 16'h565A, 16'h6A9A, 16'h66A5, 16'h6A6A};
        exp_sq = 16'h0000;

        // Reset with stall and flush asserted and busy inputs
        rst_n = 1'b0; stall = 1'b1; flush = 1'b1;
        set_instr(1'b1, 4'hE, 2'b11, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_flags", flags_q, 4'b0000);
        check_val("reset_mem", mem_pkt, '0);
        check_val("reset_squash", squash_count, 16'h0000);
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0;

        // SUBS setting Z, then BEQ
        set_instr(1'b1, 4'hE, 2'b11, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 32'h5, 32'h7);
        exp_q.push_back(pkt(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 32'h5, 32'h7));
        tick("subs_mem");
        check_val("subs_flags", flags_q, 4'b0100);
        set_instr(1'b1, 4'h0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        #1;
        check_val("beq_cond_ex", cond_ex, 1'b1);
        exp_q.push_back(pkt(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0));
        tick("beq_mem");
        check_val("beq_flags", flags_q, 4'b0100);

        // Full condition table under several flag values, stalled so nothing moves
        for (int i = 0; i < 7; i++) begin
            set_flags(tbl_flags[i]);
            stall = 1'b1;
            mask = tbl_mask[i];
            for (int c = 0; c < 16; c++) begin
                cond = c[3:0];
                #1;
                check_val($sformatf("cond_%0h_flags_%b", c, tbl_flags[i]), cond_ex, mask[c]);
            end
            stall = 1'b0;
        end
        check_val("table_squash", squash_count, exp_sq);

        // Squash: EQ with Z=0 keeps valid but drops controls and flag writes
        set_flags(4'b0000);
        set_instr(1'b1, 4'h0, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        #1;
        check_val("squash_cond_ex", cond_ex, 1'b0);
        exp_q.push_back(pkt(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 32'hDEAD_BEEF, 32'h0BAD_F00D));
        if (CNT_EN) exp_sq = exp_sq + 16'h1;
        tick("squash_mem");
        check_val("squash_flags", flags_q, 4'b0000);
        check_val("squash_count_1", squash_count, exp_sq);

        // Empty slot with a passing condition: not valid, no controls, no squash
        set_instr(1'b0, 4'hE, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 4'h6, 32'h11, 32'h22);
        exp_q.push_back(pkt(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 32'h11, 32'h22));
        tick("invalid_mem");
        check_val("invalid_flags", flags_q, 4'b0000);
        check_val("invalid_squash", squash_count, exp_sq);

        // Partial flag writes
        set_flags(4'b1111);
        set_instr(1'b1, 4'hE, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
        exp_q.push_back(pkt(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0));
        tick("partial_nz_mem");
        check_val("partial_nz", flags_q, 4'b0011);
        set_instr(1'b1, 4'hE, 2'b01, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
        exp_q.push_back(pkt(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0));
        tick("partial_cv_mem");
        check_val("partial_cv", flags_q, 4'b0000);
        set_instr(1'b1, 4'hE, 2'b00, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
        exp_q.push_back(pkt(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0));
        tick("no_flag_write_mem");
        check_val("no_flag_write", flags_q, 4'b0000);

        // Back-to-back flag setters each see the predecessor's flags
        set_flags(4'b0010);
        set_instr(1'b1, 4'h2, 2'b11, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 32'hA, 32'hB);
        #1;
        check_val("b2b_cs_cond_ex", cond_ex, 1'b1);
        exp_q.push_back(pkt(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 32'hA, 32'hB));
        tick("b2b_cs_mem");
        check_val("b2b_cs_flags", flags_q, 4'b1000);
        set_instr(1'b1, 4'h4, 2'b11, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 32'hC, 32'hD);
        #1;
        check_val("b2b_mi_cond_ex", cond_ex, 1'b1);
        exp_q.push_back(pkt(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 32'hC, 32'hD));
        tick("b2b_mi_mem");
        check_val("b2b_mi_flags", flags_q, 4'b0001);

        // Stall+flush holds everything; then flush alone inserts a bubble
        stall = 1'b1; flush = 1'b1;
        set_instr(1'b1, 4'h0, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 4'h9, 32'h99, 32'h88);
        exp_q.push_back(pkt(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 32'hC, 32'hD));
        tick("stall_flush_mem");
        check_val("stall_flush_flags", flags_q, 4'b0001);
        check_val("stall_flush_squash", squash_count, exp_sq);
        stall = 1'b0;
        set_instr(1'b1, 4'hE, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 4'h9, 32'h99, 32'h88);
        tick("flush_tick");
        check_val("flush_valid_ctrl", {mem_valid, mem_reg_write, mem_mem_write, mem_pc_src, mem_mem_to_reg}, 5'b0);
        check_val("flush_flags", flags_q, 4'b0001);
        check_val("flush_squash", squash_count, exp_sq);
        flush = 1'b0;

        // Reset mid-operation discards EX/MEM
        set_instr(1'b1, 4'hE, 2'b11, 4'b0110, 1'b1, 1'b1, 1'b1, 1'b1, 4'h7, 32'h77, 32'h66);
        exp_q.push_back(pkt(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h7, 32'h77, 32'h66));
        tick("pre_reset_mem");
        rst_n = 1'b0;
        exp_q.push_back('0);
        tick("mid_reset_mem");
        check_val("mid_reset_flags", flags_q, 4'b0000);
        check_val("mid_reset_squash", squash_count, 16'h0000);
        rst_n = 1'b1;
        exp_sq = 16'h0000;

        // Continuous squashes: counter saturates, or stays zero when not built
        set_instr(1'b1, 4'h0, 2'b11, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
`ifdef CONDEX_SQUASH_CNT_EN
        repeat (65534) @(posedge clk);
        #1;
        check_val("sat_fffe", squash_count, 16'hFFFE);
        @(posedge clk);
        #1;
        check_val("sat_ffff", squash_count, 16'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        check_val("sat_hold", squash_count, 16'hFFFF);
`else
        repeat (20) @(posedge clk);
        #1;
        check_val("no_counter", squash_count, 16'h0000);
`endif
        check_val("sat_flags", flags_q, 4'b0000);
        check_val("sat_mem_valid_ctrl", {mem_valid, mem_reg_write}, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_exec_stage.md
# cond_exec_stage

Execute-to-memory stage of the ARM core that sits directly downstream of the N-bit ALU. Each cycle it takes the ALU result and NZCV flags for the instruction in EX and holds the architectural NZCV register. It evaluates the instruction's 4-bit condition field against that register and gates the write-enables. It then registers the surviving instruction into the EX/MEM pipeline register, with stall and flush control from the hazard unit.

## Interface
- N, default 32, datapath width of ALU result and store data
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- ex_valid  input  1  EX holds a real instruction
- stall  input  1  hold EX/MEM register and flags this cycle
- flush  input  1  kill the EX instruction (bubble into MEM)
- cond  input  4  ARM condition field of EX instruction
- flag_write  input  2  bit1 updates N,Z; bit0 updates C,V
- reg_write_in, mem_write_in, pc_src_in, mem_to_reg_in  input  1 each  decoded controls
- wa_in  input  4  destination register
- alu_result  input  N  ALU RESULT
- alu_flags  input  4  ALU Flags, [3]=N [2]=Z [1]=C [0]=V
- write_data  input  N  store data
- cond_ex  output  1  combinational: condition passes for current EX instruction
- flags_q  output  4  architectural NZCV register
- mem_valid, mem_reg_write, mem_mem_write, mem_pc_src, mem_mem_to_reg  output  1 each  registered gated controls
- mem_wa  output  4  registered destination
- mem_alu_result, mem_write_data  output  N  registered data
- squash_count  output  16  squashed-instruction counter (see Configuration)

## Operation
- cond_ex is evaluated from cond and flags_q using ARM encodings: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 never (0).
- Instruction "advances" when stall=0 and flush=0. An advancing instruction "executes" when ex_valid=1 and cond_ex=1.
- Executing instruction: flags_q[3:2] <= alu_flags[3:2] if flag_write[1], and flags_q[1:0] <= alu_flags[1:0] if flag_write[0]. EX/MEM loads all inputs with mem_valid=1 and the controls passed through unchanged.
- Advancing but not executing: flags unchanged; EX/MEM loads mem_valid=ex_valid and all four controls 0; data and wa loaded as-is (don't-care).
- stall=1, with or without flush: EX/MEM and flags_q hold; stall has priority over flush.
- flush=1, stall=0: EX/MEM loads a bubble (mem_valid=0, controls 0); flags unchanged.
- Flags for instruction i are visible to cond evaluation of instruction i+1 in the next cycle, so no bypass is needed.

## Timing
- Reset (rst_n=0 at a clk edge): flags_q=0000, mem_valid=0, all mem_* controls 0, mem_wa=0, mem_alu_result=0, mem_write_data=0, squash_count=0. Reset overrides stall and flush.
- Reset asserted mid-operation discards the EX/MEM contents.
- Latency: 1 cycle from EX inputs to mem_* outputs and flags_q.
- cond_ex: zero-cycle combinational path from cond and flags_q.
- Back-to-back flag-setting instructions: each sees the flags written by its predecessor.

## Configuration
- CONDEX_SQUASH_CNT_EN defined: squash_count increments by 1 on each clock edge where an advancing instruction has ex_valid=1 and cond_ex=0. It saturates at 16'hFFFF and resets to 0.
- Undefined: squash_count is tied to 16'h0000 and no counter logic is built; all other behaviour is identical.

## Test plan
- Reset: rst_n=0 for 2 cycles with stall=1 and flush=1 -> flags_q=0000, mem_valid=0, all mem_* = 0.
- SUBS then BEQ: cycle 1 alu_flags=0100, flag_write=11, cond=1110 -> flags_q=0100 next cycle. Cycle 2 cond=0000, pc_src_in=1 -> cond_ex=1, mem_pc_src=1.
- Squash: flags_q=0000, cond=0000, reg_write_in=1, alu_result=32'hDEADBEEF -> mem_valid=1, mem_reg_write=0, flags_q unchanged, squash_count +1 (macro defined).
- Partial flag write: flags_q=1111, alu_flags=0000, flag_write=10 -> flags_q=0011.
- Stall then flush: stall=1 and flush=1 for one cycle -> mem_* and flags_q hold. Next cycle stall=0, flush=1 -> mem_valid=0, flags_q unchanged.
- Counter saturation (macro defined): force 65536 squashes -> squash_count stays 16'hFFFF. Macro undefined -> squash_count=0 throughout.
